// File: rtl/sig_strength_resolver.sv
// Observer for a multi-driver, strength-qualified net: resolves N driver lanes per bit,
// registers the result and tracks settling, stability and conflict episodes.
module sig_strength_resolver #(
    parameter int unsigned W    = 100,
    parameter int unsigned N    = 2,
    parameter int unsigned SEL  = 50,
    parameter int unsigned HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     drv_en,
    input  logic [N*W-1:0]   drv_val,
    input  logic [2*N-1:0]   drv_str,
    input  logic             clr_sticky,
    output logic [W-1:0]     res_val,
    output logic [W-1:0]     res_known,
    output logic             tap,
    output logic             stable,
    output logic             conflict,
    output logic             conflict_sticky,
    output logic [15:0]      conflict_cnt
);

    localparam int unsigned CNT_W = (HOLD < 2) ? 1 : $clog2(HOLD + 1);
    localparam int unsigned EPI_W = 16;

    typedef enum logic [1:0] {
        SETTLING = 2'd0,
        STABLE   = 2'd1,
        CONFLICT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [W-1:0]       res_val_q, res_val_d;
    logic [W-1:0]       res_known_q, res_known_d;
    logic               conflict_q, conflict_d;
    logic               stable_q, stable_d;
    logic               sticky_q, sticky_d;
    logic [EPI_W-1:0]   cnt_q, cnt_d;

    logic [1:0]         str_max;
    logic [W-1:0]       ones, zeros;
    logic               changed;

    // Strongest participating strength is lane-wide, so only lanes at that level vote per bit.
    always_comb begin
        str_max = 2'd0;
        for (int i = 0; i < int'(N); i++) begin
            if (drv_en[i] && (drv_str[2*i +: 2] > str_max)) begin
                str_max = drv_str[2*i +: 2];
            end
        end
        ones  = '0;
        zeros = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (drv_en[i] && (str_max != 2'd0) && (drv_str[2*i +: 2] == str_max)) begin
                ones  = ones  |  drv_val[i*W +: W];
                zeros = zeros | ~drv_val[i*W +: W];
            end
        end
        res_val_d   = ones & ~zeros;
        res_known_d = ones ^ zeros;
        conflict_d  = |(ones & zeros);
        changed     = (res_val_d != res_val_q) || (res_known_d != res_known_q);
    end

    // Settling FSM judged on the value about to be registered, so stable tracks res_val edge for edge.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            SETTLING: begin
                if (conflict_d) begin
                    state_d = CONFLICT;
                    hold_d  = '0;
                end else if (changed) begin
                    hold_d  = '0;
                end else if (hold_q + CNT_W'(1) == CNT_W'(HOLD)) begin
                    state_d = STABLE;
                    hold_d  = '0;
                end else begin
                    hold_d  = hold_q + CNT_W'(1);
                end
            end
            STABLE: begin
                if (conflict_d) begin
                    state_d = CONFLICT;
                    hold_d  = '0;
                end else if (changed) begin
                    state_d = SETTLING;
                    hold_d  = '0;
                end
            end
            CONFLICT: begin
                if (!conflict_d) begin
                    state_d = SETTLING;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = SETTLING;
                hold_d  = '0;
            end
        endcase
        stable_d = (state_d == STABLE);
    end

    // Set outranks clear: a conflict either being registered or currently visible keeps sticky high.
    always_comb begin
        sticky_d = conflict_d | conflict_q | (sticky_q & ~clr_sticky);
        cnt_d    = cnt_q;
        if (conflict_d && !conflict_q && (cnt_q != {EPI_W{1'b1}})) begin
            cnt_d = cnt_q + EPI_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SETTLING;
            hold_q      <= '0;
            res_val_q   <= '0;
            res_known_q <= '0;
            conflict_q  <= 1'b0;
            stable_q    <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            res_val_q   <= res_val_d;
            res_known_q <= res_known_d;
            conflict_q  <= conflict_d;
            stable_q    <= stable_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign res_val         = res_val_q;
    assign res_known       = res_known_q;
    assign tap             = res_val_q[SEL];
    assign stable          = stable_q;
    assign conflict        = conflict_q;
    assign conflict_sticky = sticky_q;
    assign conflict_cnt    = cnt_q;

endmodule

// File: tb/tb_sig_strength_resolver.sv
// Bench for sig_strength_resolver: directed scenarios then random lane traffic against a per-bit model.
module tb_sig_strength_resolver;

    localparam int unsigned W    = 100;
    localparam int unsigned N    = 2;
    localparam int unsigned SEL  = 50;
    localparam int unsigned HOLD = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     drv_en;
    logic [N*W-1:0]   drv_val;
    logic [2*N-1:0]   drv_str;
    logic             clr_sticky;
    logic [W-1:0]     res_val;
    logic [W-1:0]     res_known;
    logic             tap;
    logic             stable;
    logic             conflict;
    logic             conflict_sticky;
    logic [15:0]      conflict_cnt;

    logic [W-1:0]     lane_v [N];
    logic [1:0]       lane_s [N];

    int vectors = 0;
    int miscompares = 0;

    // model state
    logic [W-1:0] m_val, m_known;
    bit           m_conf, m_sticky;
    int           m_cnt, m_run;

    sig_strength_resolver #(.W(W), .N(N), .SEL(SEL), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .drv_en(drv_en), .drv_val(drv_val), .drv_str(drv_str),
        .clr_sticky(clr_sticky), .res_val(res_val), .res_known(res_known), .tap(tap),
        .stable(stable), .conflict(conflict), .conflict_sticky(conflict_sticky),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            drv_val[i*W +: W] = lane_v[i];
            drv_str[2*i +: 2] = lane_s[i];
        end
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_val = '0; m_known = '0; m_conf = 0; m_sticky = 0; m_cnt = 0; m_run = 0;
    endtask

    // Per-bit vote: strongest participants decide; disagreement among them is a conflict.
    task automatic model_step();
        logic [W-1:0] nv, nk;
        bit nc, quiet;
        nv = '0; nk = '0; nc = 0;
        for (int b = 0; b < int'(W); b++) begin
            int smax, n1, n0;
            smax = 0; n1 = 0; n0 = 0;
            for (int i = 0; i < int'(N); i++)
                if (drv_en[i] && int'(lane_s[i]) > smax) smax = int'(lane_s[i]);
            for (int i = 0; i < int'(N); i++)
                if (drv_en[i] && smax > 0 && int'(lane_s[i]) == smax) begin
                    if (lane_v[i][b]) n1++; else n0++;
                end
            if (n1 + n0 > 0) begin
                if (n0 == 0) begin nv[b] = 1'b1; nk[b] = 1'b1; end
                else if (n1 == 0) nk[b] = 1'b1;
                else nc = 1;
            end
        end
        quiet = !nc && !m_conf && (nv == m_val) && (nk == m_known);
        m_run = quiet ? ((m_run < int'(HOLD)) ? m_run + 1 : m_run) : 0;
        m_sticky = nc || m_conf || (m_sticky && !clr_sticky);
        if (nc && !m_conf && m_cnt < 65535) m_cnt++;
        m_val = nv; m_known = nk; m_conf = nc;
    endtask

    task automatic check_all(input string ph);
        check({ph, ".res_val"},   res_val,   m_val);
        check({ph, ".res_known"}, res_known, m_known);
        check({ph, ".tap"},       W'(tap),   W'(m_val[SEL]));
        check({ph, ".stable"},    W'(stable), W'(m_run >= int'(HOLD)));
        check({ph, ".conflict"},  W'(conflict), W'(m_conf));
        check({ph, ".sticky"},    W'(conflict_sticky), W'(m_sticky));
        check({ph, ".cnt"},       W'(conflict_cnt), W'(m_cnt));
    endtask

    task automatic tick(input string ph);
        model_step();
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    task automatic set_lane(input int i, input bit en, input logic [1:0] s, input logic [W-1:0] v);
        drv_en[i] = en; lane_s[i] = s; lane_v[i] = v;
    endtask

    initial begin
        logic [W-1:0] ones, bit_sel, pat_a;
        logic [W-1:0] pats [4];
        ones = '1;
        bit_sel = '0; bit_sel[SEL] = 1'b1;
        pat_a = {$urandom, $urandom, $urandom, $urandom};
        pats[0] = '0; pats[1] = ones; pats[2] = pat_a; pats[3] = pat_a ^ bit_sel;

        rst = 1'b1; clr_sticky = 1'b0; drv_en = '0;
        for (int i = 0; i < int'(N); i++) begin lane_v[i] = '0; lane_s[i] = 2'd0; end
        model_reset();
        set_lane(0, 1, 2'd1, '0);
        set_lane(1, 1, 2'd3, ones);
        #12;
        check_all("reset");
        @(negedge clk); rst = 1'b0;

        // weak zeros versus strong ones
        tick("strong_wins");
        check("strong_wins.val_ones", res_val, ones);
        for (int c = 0; c < 5; c++) tick("settle1");
        check("settle1.stable_const", W'(stable), W'(1));

        set_lane(1, 0, 2'd3, ones);
        tick("drop_lane1");
        check("drop_lane1.stable_low", W'(stable), W'(0));
        for (int c = 0; c < 5; c++) tick("settle2");

        // equal-strength disagreement on the tapped bit only
        set_lane(0, 1, 2'd3, '0);
        set_lane(1, 1, 2'd3, bit_sel);
        tick("conflict_on");
        check("conflict_on.known_sel", W'(res_known[SEL]), W'(0));
        for (int t = 0; t < 2; t++) begin
            set_lane(1, 1, 2'd3, '0);
            tick("conflict_off");
            set_lane(1, 1, 2'd3, bit_sel);
            tick("conflict_again");
        end
        check("toggle.cnt3", W'(conflict_cnt), W'(3));
        clr_sticky = 1'b1;
        tick("clr_during_conflict");
        set_lane(1, 1, 2'd3, '0);
        tick("conflict_removed_clr");
        tick("clr_quiet");
        clr_sticky = 1'b0;
        check("clr_quiet.sticky0", W'(conflict_sticky), W'(0));
        for (int c = 0; c < 5; c++) tick("settle3");

        // enabled at highz, then nothing enabled
        set_lane(0, 1, 2'd0, ones);
        set_lane(1, 1, 2'd0, pat_a);
        for (int c = 0; c < 6; c++) tick("highz");
        set_lane(0, 0, 2'd3, ones);
        set_lane(1, 0, 2'd2, ones);
        for (int c = 0; c < 6; c++) tick("none_en");

        // reach STABLE with a conflict history, then async reset between edges
        set_lane(0, 1, 2'd2, pat_a);
        for (int c = 0; c < 6; c++) tick("pre_reset");
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst.cnt0", W'(conflict_cnt), W'(0));
        @(negedge clk); rst = 1'b0;

        // random traffic with sticky inputs so settling and conflicts both occur
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                int i;
                i = int'($urandom_range(0, N - 1));
                set_lane(i, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                         pats[$urandom_range(0, 3)]);
            end
            clr_sticky = ($urandom_range(0, 3) == 0);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
